// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (I-side) and
// the memory stage (D-side). D wins ties, handoff is back-to-back, and stuck accesses time out.
module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        IReq_i,
    input  logic [31:0] IAddr_i,
    output logic [31:0] IRdata_o,
    output logic        IValid_o,

    input  logic        DReq_i,
    input  logic        DWe_i,
    input  logic [31:0] DAddr_i,
    input  logic [31:0] DWdata_i,
    input  logic [3:0]  DByteEn_i,
    output logic [31:0] DRdata_o,
    output logic        DValid_o,

    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [31:0] MemWdata_o,
    output logic [3:0]  MemByteEn_o,
    input  logic [31:0] MemRdata_i,
    input  logic        MemAck_i,

    output logic        StallIMem_o,
    output logic        StallDMem_o,
    output logic        Err_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last permitted busy cycle; it counts ack-less cycles from 0.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic busy;
    logic timeout_hit;
    logic grant_d;
    logic grant_i;

    assign busy        = (state != IDLE);
    assign timeout_hit = (TIMEOUT != 0) && busy && !MemAck_i && (wait_cnt == CNT_LAST);

    assign IValid_o = (state == BUSY_I) && (MemAck_i || timeout_hit);
    assign DValid_o = (state == BUSY_D) && (MemAck_i || timeout_hit);
    assign IRdata_o = ((state == BUSY_I) && MemAck_i) ? MemRdata_i : '0;
    assign DRdata_o = ((state == BUSY_D) && MemAck_i && !MemWe_o) ? MemRdata_i : '0;

    assign StallIMem_o = IReq_i & ~IValid_o;
    assign StallDMem_o = DReq_i & ~DValid_o;

    // The side just acked is never re-granted: its request line still shows the finished access.
    assign grant_d = DReq_i && ((state == IDLE) || ((state == BUSY_I) && MemAck_i));
    assign grant_i = IReq_i && (((state == IDLE) && !DReq_i) || ((state == BUSY_D) && MemAck_i));

    // NOTE: every register here uses <= so all updates see pre-edge values; the async
    // reset branch covers every register, including the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            MemReq_o    <= 1'b0;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= '0;
            MemWdata_o  <= '0;
            MemByteEn_o <= '0;
            Err_o       <= 1'b0;
        end else if (grant_d) begin
            state       <= BUSY_D;
            wait_cnt    <= '0;
            MemReq_o    <= 1'b1;
            MemWe_o     <= DWe_i;
            MemAddr_o   <= DAddr_i;
            MemWdata_o  <= DWdata_i;
            MemByteEn_o <= DByteEn_i;
        end else if (grant_i) begin
            state       <= BUSY_I;
            wait_cnt    <= '0;
            MemReq_o    <= 1'b1;
            MemWe_o     <= 1'b0;
            MemAddr_o   <= IAddr_i;
            MemWdata_o  <= '0;
            MemByteEn_o <= 4'b1111;
        end else if (IValid_o || DValid_o) begin
            state    <= IDLE;
            MemReq_o <= 1'b0;
            if (timeout_hit) begin
                Err_o <= 1'b1;
            end
        end else if (busy) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for fetch/load/store traffic plus
// hand-written sequences for alternation, timeout and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        IReq_i, DReq_i, DWe_i, MemAck_i;
    logic [31:0] IAddr_i, DAddr_i, DWdata_i, MemRdata_i;
    logic [3:0]  DByteEn_i;
    logic [31:0] IRdata_o, DRdata_o, MemAddr_o, MemWdata_o;
    logic        IValid_o, DValid_o, MemReq_o, MemWe_o, StallIMem_o, StallDMem_o, Err_o;
    logic [3:0]  MemByteEn_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IRdata_o(IRdata_o), .IValid_o(IValid_o),
        .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWdata_i(DWdata_i),
        .DByteEn_i(DByteEn_i), .DRdata_o(DRdata_o), .DValid_o(DValid_o),
        .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
        .MemWdata_o(MemWdata_o), .MemByteEn_o(MemByteEn_o),
        .MemRdata_i(MemRdata_i), .MemAck_i(MemAck_i),
        .StallIMem_o(StallIMem_o), .StallDMem_o(StallDMem_o), .Err_o(Err_o)
    );

    typedef struct {
        logic        ireq;  logic [31:0] iaddr;
        logic        dreq;  logic dwe; logic [31:0] daddr; logic [31:0] dwdata; logic [3:0] dbe;
        logic        mack;  logic [31:0] mrdata;
        logic        e_mreq; logic e_mwe; logic [31:0] e_maddr; logic [31:0] e_mwdata; logic [3:0] e_mbe;
        logic        e_ivalid; logic [31:0] e_irdata; logic e_dvalid; logic [31:0] e_drdata;
        logic        e_stall_i; logic e_stall_d;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order[6];
        int  ng, dn, inn, cyc;
        bit  d_done, i_done;

        // Order: ireq iaddr dreq dwe daddr dwdata dbe mack mrdata |
        //        mreq mwe maddr mwdata mbe ivalid irdata dvalid drdata stall_i stall_d
        // Fetch only: request at c0, ack at c2.
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                     1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                     1'b1, 1'b0, 32'h100, '0, 4'hF, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'hDEADBEEF,
                     1'b1, 1'b0, 32'h100, '0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                     1'b0, 1'b0, 32'h100, '0, 4'hF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0};
        // Simultaneous: D load wins, I follows back-to-back.
        vecs[4]  = '{1'b1, 32'h300, 1'b1, 1'b0, 32'h200, '0, 4'hF, 1'b0, '0,
                     1'b0, 1'b0, 32'h100, '0, 4'hF, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 32'h300, 1'b1, 1'b0, 32'h200, '0, 4'hF, 1'b1, 32'hAAAA5555,
                     1'b1, 1'b0, 32'h200, '0, 4'hF, 1'b0, '0, 1'b1, 32'hAAAA5555, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h300, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h11112222,
                     1'b1, 1'b0, 32'h300, '0, 4'hF, 1'b1, 32'h11112222, 1'b0, '0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0,
                     1'b0, 1'b0, 32'h300, '0, 4'hF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0};
        // Store: Mem* mirrors the request, no read data returned.
        vecs[8]  = '{1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0, '0,
                     1'b0, 1'b0, 32'h300, '0, 4'hF, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0, '0,
                     1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b1, 32'hFFFFFFFF,
                     1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0, '0, 1'b1, '0, 1'b0, 1'b0};
        // Ack while idle is ignored; Mem* registers hold.
        vecs[11] = '{1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h77,
                     1'b0, 1'b1, 32'h40, 32'h12345678, 4'h3, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0};

        // Reset state, with requests and a stray ack present.
        rst = 1'b1;
        IReq_i = 1'b1; IAddr_i = '0; DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = '0;
        DWdata_i = '0; DByteEn_i = '0; MemAck_i = 1'b1; MemRdata_i = 32'h5555;
        #2;
        check("rst mreq", MemReq_o, 1'b0);
        check("rst mwe", MemWe_o, 1'b0);
        check("rst maddr", MemAddr_o, 32'h0);
        check("rst mwdata", MemWdata_o, 32'h0);
        check("rst mbe", MemByteEn_o, 4'h0);
        check("rst err", Err_o, 1'b0);
        check("rst ivalid", IValid_o, 1'b0);
        check("rst dvalid", DValid_o, 1'b0);
        check("rst stall_i", StallIMem_o, 1'b1);
        check("rst stall_d", StallDMem_o, 1'b1);
        IReq_i = 1'b0; DReq_i = 1'b0; MemAck_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            IReq_i = vecs[i].ireq;  IAddr_i = vecs[i].iaddr;
            DReq_i = vecs[i].dreq;  DWe_i = vecs[i].dwe; DAddr_i = vecs[i].daddr;
            DWdata_i = vecs[i].dwdata; DByteEn_i = vecs[i].dbe;
            MemAck_i = vecs[i].mack; MemRdata_i = vecs[i].mrdata;
            #1;
            check($sformatf("v%0d mreq", i),    MemReq_o,    vecs[i].e_mreq);
            check($sformatf("v%0d mwe", i),     MemWe_o,     vecs[i].e_mwe);
            check($sformatf("v%0d maddr", i),   MemAddr_o,   vecs[i].e_maddr);
            check($sformatf("v%0d mwdata", i),  MemWdata_o,  vecs[i].e_mwdata);
            check($sformatf("v%0d mbe", i),     MemByteEn_o, vecs[i].e_mbe);
            check($sformatf("v%0d ivalid", i),  IValid_o,    vecs[i].e_ivalid);
            check($sformatf("v%0d irdata", i),  IRdata_o,    vecs[i].e_irdata);
            check($sformatf("v%0d dvalid", i),  DValid_o,    vecs[i].e_dvalid);
            check($sformatf("v%0d drdata", i),  DRdata_o,    vecs[i].e_drdata);
            check($sformatf("v%0d stall_i", i), StallIMem_o, vecs[i].e_stall_i);
            check($sformatf("v%0d stall_d", i), StallDMem_o, vecs[i].e_stall_d);
            check($sformatf("v%0d err", i),     Err_o,       1'b0);
        end

        // Alternation: D held across 3 loads while fetches are pending; memory acks at once.
        @(negedge clk);
        IReq_i = 1'b1; IAddr_i = 32'h1000; DReq_i = 1'b1; DWe_i = 1'b0;
        DAddr_i = 32'h2000; DByteEn_i = 4'hF; MemAck_i = 1'b0;
        ng = 0; dn = 0; inn = 0; cyc = 0; d_done = 1'b0; i_done = 1'b0;
        while (!(dn == 3 && inn == 2) && cyc < 40) begin
            @(negedge clk);
            if (d_done) begin
                if (dn < 3) DAddr_i = DAddr_i + 32'd4;
                else        DReq_i = 1'b0;
            end
            if (i_done) begin
                if (inn < 2) IAddr_i = IAddr_i + 32'd4;
                else         IReq_i = 1'b0;
            end
            MemAck_i = MemReq_o;
            MemRdata_i = MemAddr_o ^ 32'hFFFF0000;
            #1;
            if (MemReq_o && ng < 6) begin
                order[ng] = MemAddr_o[13] ? 2'd2 : 2'd1;
                ng++;
            end
            d_done = DValid_o;
            i_done = IValid_o;
            if (DValid_o) begin
                check($sformatf("alt d%0d rdata", dn), DRdata_o, DAddr_i ^ 32'hFFFF0000);
                dn++;
            end
            if (IValid_o) begin
                check($sformatf("alt i%0d rdata", inn), IRdata_o, IAddr_i ^ 32'hFFFF0000);
                inn++;
            end
            cyc++;
        end
        check("alt completed in budget", (dn == 3 && inn == 2), 1'b1);
        check("alt grant count", ng, 5);
        check("alt grant0 D", order[0], 2'd2);
        check("alt grant1 I", order[1], 2'd1);
        check("alt grant2 D", order[2], 2'd2);
        check("alt grant3 I", order[3], 2'd1);
        @(negedge clk);
        DReq_i = 1'b0; IReq_i = 1'b0; MemAck_i = 1'b0;

        // Timeout: fetch never acked, TIMEOUT=4.
        @(negedge clk);
        IReq_i = 1'b1; IAddr_i = 32'h500;
        #1;
        check("to issue stall_i", StallIMem_o, 1'b1);
        check("to issue mreq", MemReq_o, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("to busy%0d mreq", k), MemReq_o, 1'b1);
            check($sformatf("to busy%0d maddr", k), MemAddr_o, 32'h500);
            check($sformatf("to busy%0d ivalid", k), IValid_o, (k == 4));
            check($sformatf("to busy%0d irdata", k), IRdata_o, 32'h0);
            check($sformatf("to busy%0d err", k), Err_o, 1'b0);
        end
        @(negedge clk);
        IReq_i = 1'b0;
        #1;
        check("to after err", Err_o, 1'b1);
        check("to after mreq", MemReq_o, 1'b0);
        check("to after ivalid", IValid_o, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("to err sticky", Err_o, 1'b1);

        // Reset mid-access in BUSY_D, then regrant of the still-held load.
        @(negedge clk);
        DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h600; DByteEn_i = 4'hF;
        @(negedge clk);
        #1;
        check("rm busy mreq", MemReq_o, 1'b1);
        check("rm busy maddr", MemAddr_o, 32'h600);
        MemAck_i = 1'b1; MemRdata_i = 32'h1234; rst = 1'b1;
        #1;
        check("rm rst mreq", MemReq_o, 1'b0);
        check("rm rst dvalid", DValid_o, 1'b0);
        check("rm rst drdata", DRdata_o, 32'h0);
        check("rm rst err", Err_o, 1'b0);
        check("rm rst stall_d", StallDMem_o, 1'b1);
        MemAck_i = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rm regrant mreq", MemReq_o, 1'b1);
        check("rm regrant maddr", MemAddr_o, 32'h600);
        MemAck_i = 1'b1; MemRdata_i = 32'hCAFE0001;
        #1;
        check("rm regrant dvalid", DValid_o, 1'b1);
        check("rm regrant drdata", DRdata_o, 32'hCAFE0001);
        @(negedge clk);
        DReq_i = 1'b0; MemAck_i = 1'b0;
        #1;
        check("rm final mreq", MemReq_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
